pmt_fifo_sync: RTL and testbench

//  Clocked, parametrised successor of the single-stage permit (pmt) click FIFO.

---
 rtl/pmt_fifo_sync.sv | 66 ++++++
 tb/tb_pmt_fifo_sync.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pmt_fifo_sync.sv
// pmt_fifo_sync: DEPTH-stage permit-gated token pipeline with drive/free handshake on both ends.
module pmt_fifo_sync #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_drive,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_free,
  input  logic [DEPTH-1:0] pmt,
  input  logic             i_freeNext,
  output logic             o_driveNext,
  output logic [WIDTH-1:0] o_data,
  output logic [DEPTH-1:0] o_fire,
  output logic [CW-1:0]    o_count,
  output logic             o_overflow
);
  logic [DEPTH-1:0] full_q, full_d, fire_q, fire_d, leave, ready, cap;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  // Tail-to-head: a stage is ready when empty or when its token leaves this cycle.
  always_comb begin
    leave = '0;
    ready = '0;
    cap = '0;
    leave[DEPTH-1] = full_q[DEPTH-1] & i_freeNext;
    for (int k = DEPTH - 1; k > 0; k--) begin
      ready[k] = ~full_q[k] | leave[k];
      cap[k] = full_q[k-1] & pmt[k] & ready[k];
      leave[k-1] = cap[k];
    end
    ready[0] = ~full_q[0] | leave[0];
    o_free = pmt[0] & ready[0];
    cap[0] = i_drive & o_free;
    full_d = (full_q & ~leave) | cap;
    data_d[0] = cap[0] ? i_data : data_q[0];
    for (int k = 1; k < DEPTH; k++) data_d[k] = cap[k] ? data_q[k-1] : data_q[k];
    fire_d = cap;
    count_d = count_q + CW'(cap[0]) - CW'(leave[DEPTH-1]);
    ovf_d = ovf_q | (i_drive & ~o_free);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= '0;
      fire_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
    end else begin
      full_q <= full_d;
      fire_q <= fire_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
      for (int k = 0; k < DEPTH; k++) data_q[k] <= data_d[k];
    end
  end
  assign o_driveNext = leave[DEPTH-1];
  assign o_data = data_q[DEPTH-1];
  assign o_fire = fire_q;
  assign o_count = count_q;
  assign o_overflow = ovf_q;
endmodule

// File: tb/tb_pmt_fifo_sync.sv
// tb_pmt_fifo_sync: table vectors, directed corner sequences and random traffic against a slot-array model.
module tb_pmt_fifo_sync;
  localparam int D = 4;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst, i_drive, o_free, i_freeNext, o_driveNext, o_overflow;
  logic [W-1:0] i_data, o_data;
  logic [D-1:0] pmt, o_fire;
  logic [2:0] o_count;
  pmt_fifo_sync #(.DEPTH(D), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .i_drive(i_drive), .i_data(i_data), .o_free(o_free),
    .pmt(pmt), .i_freeNext(i_freeNext), .o_driveNext(o_driveNext), .o_data(o_data),
    .o_fire(o_fire), .o_count(o_count), .o_overflow(o_overflow)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic rst, drv;
    logic [W-1:0] dat;
    logic [D-1:0] p;
    logic fn;
    logic e_free, e_dn;
    logic [W-1:0] e_data;
    logic [D-1:0] e_fire;
    logic [2:0] e_cnt;
    logic e_ovf;
  } vec_t;
  int checks = 0;
  int failures = 0;
  logic mv [D];
  logic [W-1:0] md [D];
  logic [D-1:0] m_fire;
  logic m_ovf;
  logic [W-1:0] got [$];
  vec_t tbl [$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic vec_t mk(input logic drv, input logic [W-1:0] dat, input logic [D-1:0] p,
                              input logic fn, input logic e_free, input logic e_dn,
                              input logic [W-1:0] e_data, input logic [D-1:0] e_fire,
                              input logic [2:0] e_cnt, input logic e_ovf);
    vec_t v;
    v.rst = 1'b0; v.drv = drv; v.dat = dat; v.p = p; v.fn = fn;
    v.e_free = e_free; v.e_dn = e_dn; v.e_data = e_data; v.e_fire = e_fire;
    v.e_cnt = e_cnt; v.e_ovf = e_ovf;
    return v;
  endfunction
  function automatic vec_t in_only(input logic r, input logic drv, input logic [W-1:0] dat,
                                   input logic [D-1:0] p, input logic fn);
    vec_t v = mk(drv, dat, p, fn, 0, 0, 0, 0, 0, 0);
    v.rst = r;
    return v;
  endfunction
  // Model: process slots from the tail so a slot vacated this cycle can be refilled behind it.
  task automatic step(input vec_t t, input bit use_t);
    logic nv [D];
    logic [W-1:0] nd [D];
    logic [D-1:0] fl;
    logic em, fr;
    logic [W-1:0] ed;
    int cnt;
    rst = t.rst; i_drive = t.drv; i_data = t.dat; pmt = t.p; i_freeNext = t.fn;
    #1;
    nv = mv; nd = md; fl = '0; em = 1'b0; ed = '0; cnt = 0;
    for (int k = D - 1; k >= 0; k--) begin
      if (nv[k]) begin
        if (k == D - 1) begin
          if (t.fn) begin em = 1'b1; ed = nd[k]; nv[k] = 1'b0; end
        end else if (t.p[k+1] && !nv[k+1]) begin
          nv[k+1] = 1'b1; nd[k+1] = nd[k]; nv[k] = 1'b0; fl[k+1] = 1'b1;
        end
      end
    end
    fr = t.p[0] && !nv[0];
    if (t.drv && fr) begin nv[0] = 1'b1; nd[0] = t.dat; fl[0] = 1'b1; end
    for (int k = 0; k < D; k++) cnt += int'(mv[k]);
    chk("free", o_free, fr);
    chk("driveNext", o_driveNext, em);
    if (em) chk("data", o_data, ed);
    chk("fire", o_fire, m_fire);
    chk("count", o_count, cnt);
    chk("overflow", o_overflow, m_ovf);
    if (use_t) begin
      chk("tbl_free", o_free, t.e_free);
      chk("tbl_driveNext", o_driveNext, t.e_dn);
      if (t.e_dn) chk("tbl_data", o_data, t.e_data);
      chk("tbl_fire", o_fire, t.e_fire);
      chk("tbl_count", o_count, t.e_cnt);
      chk("tbl_overflow", o_overflow, t.e_ovf);
    end
    if (o_driveNext) got.push_back(o_data);
    if (t.rst) begin
      for (int k = 0; k < D; k++) begin mv[k] = 1'b0; md[k] = '0; end
      m_fire = '0; m_ovf = 1'b0;
    end else begin
      mv = nv; md = nd; m_fire = fl; m_ovf = m_ovf | (t.drv & !fr);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; i_drive = 1'b0; i_data = '0; pmt = '1; i_freeNext = 1'b0;
    for (int k = 0; k < D; k++) begin mv[k] = 1'b0; md[k] = '0; end
    m_fire = '0; m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // T1: single token latency, fire walk
    tbl.push_back(mk(1, 8'hA5, 4'hF, 1, 1, 0, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 8'h00, 4'hF, 1, 1, 0, 0, 4'b0001, 1, 0));
    tbl.push_back(mk(0, 8'h00, 4'hF, 1, 1, 0, 0, 4'b0010, 1, 0));
    tbl.push_back(mk(0, 8'h00, 4'hF, 1, 1, 0, 0, 4'b0100, 1, 0));
    tbl.push_back(mk(0, 8'h00, 4'hF, 1, 1, 1, 8'hA5, 4'b1000, 1, 0));
    tbl.push_back(mk(0, 8'h00, 4'hF, 1, 1, 0, 0, 4'b0000, 0, 0));
    // T2: fill while blocked, overflow, then drain in order
    tbl.push_back(mk(1, 8'h01, 4'hF, 0, 1, 0, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 8'h02, 4'hF, 0, 1, 0, 0, 4'b0001, 1, 0));
    tbl.push_back(mk(1, 8'h03, 4'hF, 0, 1, 0, 0, 4'b0011, 2, 0));
    tbl.push_back(mk(1, 8'h04, 4'hF, 0, 1, 0, 0, 4'b0111, 3, 0));
    tbl.push_back(mk(1, 8'h05, 4'hF, 0, 0, 0, 0, 4'b1111, 4, 0));
    tbl.push_back(mk(0, 8'h00, 4'hF, 1, 1, 1, 8'h01, 4'b0000, 4, 1));
    tbl.push_back(mk(0, 8'h00, 4'hF, 1, 1, 1, 8'h02, 4'b1110, 3, 1));
    tbl.push_back(mk(0, 8'h00, 4'hF, 1, 1, 1, 8'h03, 4'b1100, 2, 1));
    tbl.push_back(mk(0, 8'h00, 4'hF, 1, 1, 1, 8'h04, 4'b1000, 1, 1));
    tbl.push_back(mk(0, 8'h00, 4'hF, 1, 1, 0, 0, 4'b0000, 0, 1));
    foreach (tbl[i]) step(tbl[i], 1'b1);
    // T3: pmt[2]=0 freezes tokens in stages 1 and 0
    step(in_only(1, 0, 0, 4'hF, 1), 1'b0);
    got.delete();
    step(in_only(0, 1, 8'h10, 4'b1011, 1), 1'b0);
    step(in_only(0, 1, 8'h11, 4'b1011, 1), 1'b0);
    repeat (3) step(in_only(0, 0, 0, 4'b1011, 1), 1'b0);
    chk("t3_count_held", o_count, 2);
    chk("t3_no_output", got.size(), 0);
    repeat (6) step(in_only(0, 0, 0, 4'hF, 1), 1'b0);
    chk("t3_out_n", got.size(), 2);
    if (got.size() == 2) begin
      chk("t3_first", got[0], 8'h10);
      chk("t3_second", got[1], 8'h11);
    end
    // T4: full pipe drains and refills every cycle
    step(in_only(1, 0, 0, 4'hF, 1), 1'b0);
    got.delete();
    for (int i = 0; i < 4; i++) step(in_only(0, 1, 8'h30 + 8'(i), 4'hF, 0), 1'b0);
    chk("t4_full", o_count, 4);
    for (int i = 0; i < 10; i++) begin
      step(in_only(0, 1, 8'h20 + 8'(i), 4'hF, 1), 1'b0);
      chk("t4_count", o_count, 4);
    end
    chk("t4_out_n", got.size(), 10);
    for (int i = 0; i < 10 && i < got.size(); i++)
      chk("t4_order", got[i], i < 4 ? 8'h30 + 8'(i) : 8'h20 + 8'(i - 4));
    chk("t4_no_ovf", o_overflow, 0);
    // T5: reset with drive drops everything, including the sticky overflow
    for (int i = 0; i < 3; i++) step(in_only(0, 1, 8'h40 + 8'(i), 4'hF, 0), 1'b0);
    step(in_only(0, 1, 8'h4F, 4'hE, 0), 1'b0);
    chk("t5_ovf_set", o_overflow, 1);
    step(in_only(1, 1, 8'h77, 4'hF, 1), 1'b0);
    rst = 1'b0; i_drive = 1'b0; i_freeNext = 1'b1;
    #1;
    chk("t5_count", o_count, 0);
    chk("t5_fire", o_fire, 0);
    chk("t5_dn", o_driveNext, 0);
    chk("t5_ovf", o_overflow, 0);
    got.delete();
    repeat (6) step(in_only(0, 0, 0, 4'hF, 1), 1'b0);
    chk("t5_no_stale", got.size(), 0);
    // Random traffic against the model
    for (int i = 0; i < 400; i++)
      step(in_only(($urandom_range(0, 99) == 0), 1'($urandom), 8'($urandom),
                   4'hF & ~(4'($urandom) & 4'($urandom)), 1'($urandom_range(0, 3) != 0)), 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
